fcore_program_sequencer: RTL

Fetch/issue stage directly upstream of the fCore decoder.
- Reads instruction words from the program memory.
- Replays each instruction once per active channel, tagging every beat with its channel address.
- Supplies the trailing constant word of LDC instructions on load_data.
- Stops on the STOP opcode or at the end of the program, then reports completion to the core controller.

---
 rtl/fcore_program_sequencer_if.sv | 35 +++
 rtl/fcore_program_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fcore_program_sequencer_if.sv
// Bus bundle between the fCore program sequencer, its program memory, the decoder
// and the core controller. The sequencer uses the master modport.
interface fcore_program_sequencer_if #(
    parameter int unsigned INSTRUCTION_WIDTH  = 16,
    parameter int unsigned PC_WIDTH           = 12,
    parameter int unsigned MAX_CHANNELS       = 255,
    parameter int unsigned CHANNEL_ADDR_WIDTH = 8
);
    localparam int unsigned N_CH_WIDTH = $clog2(MAX_CHANNELS);

    logic                          start;
    logic [N_CH_WIDTH-1:0]         n_channels;
    logic [PC_WIDTH-1:0]           program_length;
    logic [PC_WIDTH-1:0]           prog_addr;
    logic [INSTRUCTION_WIDTH-1:0]  prog_data;
    logic [INSTRUCTION_WIDTH-1:0]  instr_data;
    logic [CHANNEL_ADDR_WIDTH-1:0] instr_channel;
    logic                          instr_valid;
    logic [INSTRUCTION_WIDTH-1:0]  load_data;
    logic                          busy;
    logic                          done;
    logic [31:0]                   run_cycles;

    modport master (
        input  start, n_channels, program_length, prog_data,
        output prog_addr, instr_data, instr_channel, instr_valid, load_data, busy, done,
               run_cycles
    );

    modport slave (
        output start, n_channels, program_length, prog_data,
        input  prog_addr, instr_data, instr_channel, instr_valid, load_data, busy, done,
               run_cycles
    );
endinterface

// File: rtl/fcore_program_sequencer.sv
// fCore fetch/issue stage: fetches program words and replays each one per channel.
// Optional run-length counter enabled by FCORE_SEQUENCER_PERF_COUNTER_EN.
module fcore_program_sequencer #(
    parameter int unsigned            INSTRUCTION_WIDTH  = 16,
    parameter int unsigned            PC_WIDTH           = 12,
    parameter int unsigned            OPCODE_WIDTH       = 4,
    parameter int unsigned            MAX_CHANNELS       = 255,
    parameter int unsigned            CHANNEL_ADDR_WIDTH = 8,
    parameter logic [OPCODE_WIDTH-1:0] LDC_OPCODE        = 'h6,
    parameter logic [OPCODE_WIDTH-1:0] STOP_OPCODE       = 'hC
) (
    input logic                       i_clock,
    input logic                       i_reset,
    fcore_program_sequencer_if.master io_bus
);
    localparam int unsigned N_CH_WIDTH = $clog2(MAX_CHANNELS);

    typedef enum logic [2:0] {
        StIdle, StAddr, StData, StConstAddr, StConstData, StIssue, StFinish
    } state_t;

    state_t                        r_state, w_state_next;
    logic [PC_WIDTH-1:0]           r_pc, w_pc_next;
    logic [PC_WIDTH-1:0]           r_len, w_len_next;
    logic [N_CH_WIDTH-1:0]         r_nch, w_nch_next;
    logic [INSTRUCTION_WIDTH-1:0]  r_ir, w_ir_next;
    logic [CHANNEL_ADDR_WIDTH-1:0] r_count, w_count_next;
    logic [PC_WIDTH-1:0]           r_prog_addr, w_prog_addr_next;
    logic [INSTRUCTION_WIDTH-1:0]  r_instr_data, w_instr_data_next;
    logic [INSTRUCTION_WIDTH-1:0]  r_load_data, w_load_data_next;

    logic [N_CH_WIDTH-1:0]         w_n_eff;
    logic [CHANNEL_ADDR_WIDTH-1:0] w_last_chan;
    logic                          w_is_ldc, w_is_stop, w_fetch_ldc;
    logic [PC_WIDTH-1:0]           w_next_pc;

    assign w_n_eff     = (r_nch == '0) ? N_CH_WIDTH'(1) : r_nch;
    assign w_last_chan = CHANNEL_ADDR_WIDTH'(w_n_eff - N_CH_WIDTH'(1));
    assign w_is_ldc    = (r_ir[OPCODE_WIDTH-1:0] == LDC_OPCODE);
    assign w_is_stop   = (r_ir[OPCODE_WIDTH-1:0] == STOP_OPCODE);
    assign w_fetch_ldc = (io_bus.prog_data[OPCODE_WIDTH-1:0] == LDC_OPCODE);
    assign w_next_pc   = r_pc + (w_is_ldc ? PC_WIDTH'(2) : PC_WIDTH'(1));

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_len_next        = r_len;
        w_nch_next        = r_nch;
        w_ir_next         = r_ir;
        w_count_next      = r_count;
        w_prog_addr_next  = r_prog_addr;
        w_instr_data_next = r_instr_data;
        w_load_data_next  = r_load_data;
        unique case (r_state)
            StIdle: begin
                if (io_bus.start) begin
                    w_state_next     = StAddr;
                    w_pc_next        = '0;
                    w_prog_addr_next = '0;
                    w_len_next       = io_bus.program_length;
                    w_nch_next       = io_bus.n_channels;
                end
            end
            StAddr: w_state_next = (r_len == '0) ? StFinish : StData;
            StData: begin
                w_ir_next = io_bus.prog_data;
                if (w_fetch_ldc) begin
                    w_prog_addr_next = r_pc + PC_WIDTH'(1);
                    w_state_next     = StConstAddr;
                end else begin
                    // Decoder-facing registers only move when issue begins.
                    w_instr_data_next = io_bus.prog_data;
                    w_count_next      = '0;
                    w_state_next      = StIssue;
                end
            end
            StConstAddr: w_state_next = StConstData;
            StConstData: begin
                w_load_data_next  = io_bus.prog_data;
                w_instr_data_next = r_ir;
                w_count_next      = '0;
                w_state_next      = StIssue;
            end
            StIssue: begin
                if (w_is_stop || (r_count == w_last_chan)) begin
                    w_pc_next = w_next_pc;
                    if (w_is_stop || (w_next_pc >= r_len)) begin
                        w_state_next = StFinish;
                    end else begin
                        w_prog_addr_next = w_next_pc;
                        w_state_next     = StAddr;
                    end
                end else begin
                    w_count_next = r_count + CHANNEL_ADDR_WIDTH'(1);
                end
            end
            StFinish: w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state      <= StIdle;
            r_pc         <= '0;
            r_len        <= '0;
            r_nch        <= '0;
            r_ir         <= '0;
            r_count      <= '0;
            r_prog_addr  <= '0;
            r_instr_data <= '0;
            r_load_data  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_len        <= w_len_next;
            r_nch        <= w_nch_next;
            r_ir         <= w_ir_next;
            r_count      <= w_count_next;
            r_prog_addr  <= w_prog_addr_next;
            r_instr_data <= w_instr_data_next;
            r_load_data  <= w_load_data_next;
        end
    end

    assign io_bus.prog_addr     = r_prog_addr;
    assign io_bus.instr_data    = r_instr_data;
    assign io_bus.instr_channel = r_count;
    assign io_bus.instr_valid   = (r_state == StIssue);
    assign io_bus.load_data     = r_load_data;
    assign io_bus.busy          = (r_state != StIdle) && (r_state != StFinish);
    assign io_bus.done          = (r_state == StFinish);

`ifdef FCORE_SEQUENCER_PERF_COUNTER_EN
    logic [31:0] r_cycles, r_run_cycles;
    logic [31:0] w_cycles_inc;

    assign w_cycles_inc = (&r_cycles) ? r_cycles : r_cycles + 32'd1;

    // Counts every cycle of the run, the done cycle included.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_cycles     <= '0;
            r_run_cycles <= '0;
        end else begin
            if (r_state == StIdle) begin
                if (io_bus.start) r_cycles <= '0;
            end else begin
                r_cycles <= w_cycles_inc;
            end
            if (r_state == StFinish) r_run_cycles <= w_cycles_inc;
        end
    end

    assign io_bus.run_cycles = r_run_cycles;
`else
    assign io_bus.run_cycles = '0;
`endif
endmodule
